// File: rtl/mem_cmd_splitter.sv
// Splits arbitrary-length memory commands into boundary-safe sub-commands and
// folds the per-chunk status bytes back into one status per original command.
module mem_cmd_splitter #(
  parameter int unsigned BOUNDARY   = 4096,
  parameter int unsigned MAX_BYTES  = 4096,
  parameter int unsigned FLAG_DEPTH = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [63:0] s_cmd_address,
  input  logic [31:0] s_cmd_length,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [63:0] m_cmd_address,
  output logic [31:0] m_cmd_length,
  input  logic        s_sts_valid,
  output logic        s_sts_ready,
  input  logic [7:0]  s_sts_data,
  output logic        m_sts_valid,
  input  logic        m_sts_ready,
  output logic [7:0]  m_sts_data
);

  localparam int unsigned AW       = (FLAG_DEPTH > 1) ? $clog2(FLAG_DEPTH) : 1;
  localparam logic [63:0] BND      = 64'(BOUNDARY);
  localparam logic [63:0] BND_MASK = 64'(BOUNDARY) - 64'd1;
  localparam logic [63:0] MAXB     = 64'(MAX_BYTES);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FLAG_DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

  // Largest legal chunk starting at addr with rem bytes still to move.
  function automatic logic [31:0] chunk_of(input logic [63:0] addr, input logic [31:0] rem);
    logic [63:0] lim;
    lim = BND - (addr & BND_MASK);
    if (MAXB < lim) lim = MAXB;
    if ({32'd0, rem} < lim) lim = {32'd0, rem};
    return lim[31:0];
  endfunction

  state_t          state_reg;
  logic            s_cmd_ready_reg;
  logic            m_cmd_valid_reg;
  logic [63:0]     m_cmd_address_reg;
  logic [31:0]     m_cmd_length_reg;
  logic [31:0]     rem_reg;

  logic [FLAG_DEPTH-1:0] flags_vec;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic            full_reg;
  logic            empty_reg;
  logic            full_next;
  logic            empty_next;

  logic            s_sts_ready_reg;
  logic            m_sts_valid_reg;
  logic            m_sts_valid_next;
  logic [7:0]      m_sts_data_reg;
  logic [7:0]      acc_reg;

  logic            cmd_fire;
  logic            sts_fire;
  logic            last_chunk;
  logic            head_flag;
  logic [63:0]     step_addr;
  logic [31:0]     step_rem;
  logic [31:0]     step_chunk;
  logic [31:0]     accept_chunk;

  always_comb begin
    cmd_fire     = m_cmd_valid_reg && m_cmd_ready;
    sts_fire     = s_sts_valid && s_sts_ready_reg;
    // m_cmd_length_reg always holds the current chunk, m_cmd_address_reg the current address.
    last_chunk   = (rem_reg == m_cmd_length_reg);
    head_flag    = flags_vec[rd_ptr_reg];
    step_addr    = m_cmd_address_reg + {32'd0, m_cmd_length_reg};
    step_rem     = rem_reg - m_cmd_length_reg;
    step_chunk   = chunk_of(step_addr, step_rem);
    accept_chunk = chunk_of(s_cmd_address, s_cmd_length);

    count_next = count_reg;
    if (cmd_fire && !sts_fire)
      count_next = count_reg + CNT_ONE;
    else if (!cmd_fire && sts_fire)
      count_next = count_reg - CNT_ONE;
    full_next  = (count_next == DEPTH_CNT);
    empty_next = (count_next == '0);

    m_sts_valid_next = m_sts_valid_reg;
    if (m_sts_valid_reg && m_sts_ready)
      m_sts_valid_next = 1'b0;
    if (sts_fire && head_flag)
      m_sts_valid_next = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg         <= ST_IDLE;
      s_cmd_ready_reg   <= 1'b0;
      m_cmd_valid_reg   <= 1'b0;
      m_cmd_address_reg <= '0;
      m_cmd_length_reg  <= '0;
      rem_reg           <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (s_cmd_valid && s_cmd_ready_reg) begin
            state_reg         <= ST_SPLIT;
            s_cmd_ready_reg   <= 1'b0;
            rem_reg           <= s_cmd_length;
            m_cmd_address_reg <= s_cmd_address;
            m_cmd_length_reg  <= accept_chunk;
            m_cmd_valid_reg   <= !full_next;
          end else begin
            s_cmd_ready_reg <= 1'b1;
          end
        end
        ST_SPLIT: begin
          if (cmd_fire && last_chunk) begin
            state_reg       <= ST_IDLE;
            s_cmd_ready_reg <= 1'b1;
            m_cmd_valid_reg <= 1'b0;
          end else if (cmd_fire) begin
            rem_reg           <= step_rem;
            m_cmd_address_reg <= step_addr;
            m_cmd_length_reg  <= step_chunk;
            m_cmd_valid_reg   <= !full_next;
          end else begin
            m_cmd_valid_reg <= !full_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // One register per flag slot; the vector gives a simple read mux at the head.
  for (genvar gi = 0; gi < FLAG_DEPTH; gi++) begin : g_flag
    logic flag_reg;
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
        flag_reg <= 1'b0;
      else if (cmd_fire && (wr_ptr_reg == AW'(gi)))
        flag_reg <= last_chunk;
    end
    assign flags_vec[gi] = flag_reg;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (cmd_fire) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (sts_fire) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= full_next;
      empty_reg <= empty_next;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_sts_ready_reg <= 1'b0;
      m_sts_valid_reg <= 1'b0;
      m_sts_data_reg  <= '0;
      acc_reg         <= '0;
    end else begin
      m_sts_valid_reg <= m_sts_valid_next;
      // Hold off new statuses while a merged result waits downstream.
      s_sts_ready_reg <= !empty_next && !m_sts_valid_next;
      if (sts_fire) begin
        if (head_flag) begin
          m_sts_data_reg <= acc_reg | s_sts_data;
          acc_reg        <= '0;
        end else begin
          acc_reg <= acc_reg | s_sts_data;
        end
      end
    end
  end

  assign s_cmd_ready   = s_cmd_ready_reg;
  assign m_cmd_valid   = m_cmd_valid_reg;
  assign m_cmd_address = m_cmd_address_reg;
  assign m_cmd_length  = m_cmd_length_reg;
  assign s_sts_ready   = s_sts_ready_reg;
  assign m_sts_valid   = m_sts_valid_reg;
  assign m_sts_data    = m_sts_data_reg;

endmodule

// File: tb/tb_mem_cmd_splitter.sv
// Directed bench for mem_cmd_splitter: queue-based reference model checked every
// cycle by a monitor, plus literal expectations per scenario.
module tb_mem_cmd_splitter;

  localparam int DEPTH = 4;
  localparam longint unsigned BND  = 4096;
  localparam longint unsigned MAXB = 4096;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [63:0] s_cmd_address;
  logic [31:0] s_cmd_length;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [63:0] m_cmd_address;
  logic [31:0] m_cmd_length;
  logic        s_sts_valid;
  logic        s_sts_ready;
  logic [7:0]  s_sts_data;
  logic        m_sts_valid;
  logic        m_sts_ready;
  logic [7:0]  m_sts_data;

  mem_cmd_splitter #(
    .BOUNDARY  (4096),
    .MAX_BYTES (4096),
    .FLAG_DEPTH(DEPTH)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .s_cmd_address(s_cmd_address),
    .s_cmd_length (s_cmd_length),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_ready  (m_cmd_ready),
    .m_cmd_address(m_cmd_address),
    .m_cmd_length (m_cmd_length),
    .s_sts_valid  (s_sts_valid),
    .s_sts_ready  (s_sts_ready),
    .s_sts_data   (s_sts_data),
    .m_sts_valid  (m_sts_valid),
    .m_sts_ready  (m_sts_ready),
    .m_sts_data   (m_sts_data)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] len;
    logic        last;
  } sub_t;

  sub_t        exp_cmd_q[$];
  logic        out_flag_q[$];
  logic [7:0]  exp_sts_q[$];
  logic [7:0]  model_acc;
  logic [63:0] obs_addr_q[$];
  logic [31:0] obs_len_q[$];
  logic [7:0]  obs_sts_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference split: plain arithmetic on the three limits.
  function automatic void model_split(input logic [63:0] a, input logic [31:0] l);
    longint unsigned addr = a;
    longint unsigned rem  = l;
    longint unsigned c;
    sub_t s;
    do begin
      c = rem;
      if (c > MAXB) c = MAXB;
      if (c > BND - (addr % BND)) c = BND - (addr % BND);
      s.addr = addr;
      s.len  = 32'(c);
      s.last = (rem == c);
      exp_cmd_q.push_back(s);
      addr = addr + c;
      rem  = rem - c;
    end while (rem != 0);
  endfunction

  // Monitor: samples on the falling edge, predicting transfers at the next rising edge.
  initial begin
    logic        prev_cmd_pend = 1'b0;
    logic        prev_sts_pend = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [31:0] prev_len = '0;
    logic [7:0]  prev_sdata = '0;
    sub_t        e;
    logic        f;
    model_acc = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_cmd_q.delete();
        out_flag_q.delete();
        exp_sts_q.delete();
        model_acc = '0;
        prev_cmd_pend = 1'b0;
        prev_sts_pend = 1'b0;
      end else begin
        chk("sts_ready_rule", 64'(s_sts_ready), 64'(out_flag_q.size() != 0 && !m_sts_valid));
        if (m_cmd_valid) begin
          chk("cmd_ready_low_in_split", 64'(s_cmd_ready), 64'd0);
          chk("cmd_valid_needs_room", 64'(out_flag_q.size() < DEPTH), 64'd1);
        end
        if (prev_cmd_pend) begin
          chk("m_cmd_valid_held", 64'(m_cmd_valid), 64'd1);
          chk("m_cmd_address_stable", m_cmd_address, prev_addr);
          chk("m_cmd_length_stable", 64'(m_cmd_length), 64'(prev_len));
        end
        if (prev_sts_pend) begin
          chk("m_sts_valid_held", 64'(m_sts_valid), 64'd1);
          chk("m_sts_data_stable", 64'(m_sts_data), 64'(prev_sdata));
        end
        if (s_cmd_valid && s_cmd_ready)
          $display("s_cmd   addr=0x%0h len=0x%0h", s_cmd_address, s_cmd_length);
        if (m_cmd_valid && m_cmd_ready) begin
          $display("m_cmd   addr=0x%0h len=0x%0h", m_cmd_address, m_cmd_length);
          obs_addr_q.push_back(m_cmd_address);
          obs_len_q.push_back(m_cmd_length);
          if (exp_cmd_q.size() == 0) begin
            fail_now("unexpected_m_cmd", $sformatf("got addr 0x%0h, expected no sub-command", m_cmd_address));
          end else begin
            e = exp_cmd_q.pop_front();
            chk("m_cmd_address", m_cmd_address, e.addr);
            chk("m_cmd_length", 64'(m_cmd_length), 64'(e.len));
            out_flag_q.push_back(e.last);
          end
        end
        if (m_sts_valid && m_sts_ready) begin
          $display("m_sts   data=0x%02h", m_sts_data);
          obs_sts_q.push_back(m_sts_data);
          if (exp_sts_q.size() == 0)
            fail_now("unexpected_m_sts", $sformatf("got 0x%02h, expected no merged status", m_sts_data));
          else
            chk("m_sts_data", 64'(m_sts_data), 64'(exp_sts_q.pop_front()));
        end
        if (s_sts_valid && s_sts_ready) begin
          $display("s_sts   data=0x%02h", s_sts_data);
          if (out_flag_q.size() == 0) begin
            fail_now("sts_without_flag", "got a status accepted, expected none with no outstanding chunk");
          end else begin
            f = out_flag_q.pop_front();
            model_acc = model_acc | s_sts_data;
            if (f) begin
              exp_sts_q.push_back(model_acc);
              model_acc = '0;
            end
          end
        end
        prev_cmd_pend = m_cmd_valid && !m_cmd_ready;
        prev_addr     = m_cmd_address;
        prev_len      = m_cmd_length;
        prev_sts_pend = m_sts_valid && !m_sts_ready;
        prev_sdata    = m_sts_data;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l);
    bit ok = 1'b0;
    model_split(a, l);
    s_cmd_address = a;
    s_cmd_length  = l;
    s_cmd_valid   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (s_cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("s_cmd_accept", "got no s_cmd_ready, expected acceptance within 300 cycles");
    @(posedge aclk);
    #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] d);
    bit ok = 1'b0;
    s_sts_data  = d;
    s_sts_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (s_sts_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("s_sts_accept", "got no s_sts_ready, expected acceptance within 300 cycles");
    @(posedge aclk);
    #1;
    s_sts_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_len_q.delete();
    obs_sts_q.delete();
  endtask

  task automatic pin_cmd(input string t, input int i, input logic [63:0] a, input logic [31:0] l);
    if (i >= obs_addr_q.size()) begin
      fail_now($sformatf("%s_cmd%0d", t, i), $sformatf("got no sub-command, expected addr 0x%0h len 0x%0h", a, l));
    end else begin
      chk($sformatf("%s_cmd%0d_addr", t, i), obs_addr_q[i], a);
      chk($sformatf("%s_cmd%0d_len", t, i), 64'(obs_len_q[i]), 64'(l));
    end
  endtask

  task automatic pin_sts(input string t, input int i, input logic [7:0] d);
    if (i >= obs_sts_q.size())
      fail_now($sformatf("%s_sts%0d", t, i), $sformatf("got no merged status, expected 0x%02h", d));
    else
      chk($sformatf("%s_sts%0d", t, i), 64'(obs_sts_q[i]), 64'(d));
  endtask

  task automatic drained(input string t, input int ncmd, input int nsts);
    chk({t, "_cmd_count"}, 64'(obs_addr_q.size()), 64'(ncmd));
    chk({t, "_sts_count"}, 64'(obs_sts_q.size()), 64'(nsts));
    chk({t, "_cmd_left"}, 64'(exp_cmd_q.size()), 64'd0);
    chk({t, "_flag_left"}, 64'(out_flag_q.size()), 64'd0);
    chk({t, "_sts_left"}, 64'(exp_sts_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    aresetn = 1'b0;
    s_cmd_valid = 1'b0;
    s_cmd_address = '0;
    s_cmd_length = '0;
    m_cmd_ready = 1'b1;
    s_sts_valid = 1'b0;
    s_sts_data = '0;
    m_sts_ready = 1'b1;

    idle(1);
    chk("rst_s_cmd_ready", 64'(s_cmd_ready), 64'd0);
    chk("rst_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
    chk("rst_s_sts_ready", 64'(s_sts_ready), 64'd0);
    chk("rst_m_sts_valid", 64'(m_sts_valid), 64'd0);
    chk("rst_m_cmd_address", m_cmd_address, 64'd0);
    chk("rst_m_cmd_length", 64'(m_cmd_length), 64'd0);
    chk("rst_m_sts_data", 64'(m_sts_data), 64'd0);
    idle(2);
    aresetn = 1'b1;
    idle(1);
    chk("post_rst_s_cmd_ready", 64'(s_cmd_ready), 64'd1);

    // 1: boundary crossing
    clear_obs();
    send_cmd(64'h0FF0, 32'h30);
    send_sts(8'h00);
    send_sts(8'h00);
    idle(10);
    pin_cmd("t1", 0, 64'h0FF0, 32'h10);
    pin_cmd("t1", 1, 64'h1000, 32'h20);
    pin_sts("t1", 0, 8'h00);
    drained("t1", 2, 1);

    // 2: long command, merge only after the last chunk's status
    clear_obs();
    send_cmd(64'h0, 32'd10000);
    send_sts(8'h00);
    send_sts(8'h80);
    idle(3);
    chk("t2_no_early_m_sts_valid", 64'(m_sts_valid), 64'd0);
    chk("t2_no_early_m_sts", 64'(obs_sts_q.size()), 64'd0);
    send_sts(8'h01);
    idle(10);
    pin_cmd("t2", 0, 64'h0000, 32'd4096);
    pin_cmd("t2", 1, 64'h1000, 32'd4096);
    pin_cmd("t2", 2, 64'h2000, 32'd1808);
    pin_sts("t2", 0, 8'h81);
    drained("t2", 3, 1);

    // 3: zero length
    clear_obs();
    send_cmd(64'h1234, 32'd0);
    send_sts(8'h40);
    idle(10);
    pin_cmd("t3", 0, 64'h1234, 32'd0);
    pin_sts("t3", 0, 8'h40);
    drained("t3", 1, 1);

    // 4: backpressure and flag FIFO full
    clear_obs();
    m_cmd_ready = 1'b0;
    send_cmd(64'h0, 32'h8000);
    for (int i = 0; i < 20; i++) begin
      m_cmd_ready = (i % 2 == 1);
      idle(1);
    end
    m_cmd_ready = 1'b1;
    idle(3);
    chk("t4_full_count", 64'(obs_addr_q.size()), 64'd4);
    chk("t4_full_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
    send_sts(8'h00);
    idle(5);
    chk("t4_one_more_count", 64'(obs_addr_q.size()), 64'd5);
    chk("t4_one_more_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
    for (int i = 0; i < 6; i++) send_sts(8'h00);
    send_sts(8'h02);
    idle(10);
    for (int k = 0; k < 8; k++) pin_cmd("t4", k, 64'(k) * 64'h1000, 32'h1000);
    pin_sts("t4", 0, 8'h02);
    drained("t4", 8, 1);

    // 5: two back-to-back commands with a stalled merged-status output
    clear_obs();
    m_sts_ready = 1'b0;
    send_cmd(64'h0800, 32'h1000);
    chk("t5_s_cmd_ready_split", 64'(s_cmd_ready), 64'd0);
    send_cmd(64'h3000, 32'h1800);
    send_sts(8'h01);
    send_sts(8'h02);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_sts_valid) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
    if (!ok) fail_now("t5_m_sts_wait", "got no m_sts_valid, expected merged status within 100 cycles");
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_s_sts_ready", 64'(s_sts_ready), 64'd0);
      chk("t5_stall_m_sts_valid", 64'(m_sts_valid), 64'd1);
      chk("t5_stall_m_sts_data", 64'(m_sts_data), 64'h03);
      idle(1);
    end
    m_sts_ready = 1'b1;
    send_sts(8'h04);
    send_sts(8'h10);
    idle(10);
    pin_cmd("t5", 0, 64'h0800, 32'h0800);
    pin_cmd("t5", 1, 64'h1000, 32'h0800);
    pin_cmd("t5", 2, 64'h3000, 32'h1000);
    pin_cmd("t5", 3, 64'h4000, 32'h0800);
    pin_sts("t5", 0, 8'h03);
    pin_sts("t5", 1, 8'h14);
    drained("t5", 4, 2);

    // 6: reset in the middle of a split
    clear_obs();
    send_cmd(64'h0, 32'h3000);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge aclk);
      if (obs_addr_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("t6_first_chunk", "got no sub-command, expected one within 50 cycles");
    #3;
    aresetn = 1'b0;
    #1;
    chk("t6_async_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
    chk("t6_async_s_cmd_ready", 64'(s_cmd_ready), 64'd0);
    chk("t6_async_s_sts_ready", 64'(s_sts_ready), 64'd0);
    chk("t6_async_m_sts_valid", 64'(m_sts_valid), 64'd0);
    chk("t6_async_m_cmd_length", 64'(m_cmd_length), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(2);
    chk("t6_fifo_empty", 64'(s_sts_ready), 64'd0);
    chk("t6_idle_ready", 64'(s_cmd_ready), 64'd1);
    clear_obs();
    send_cmd(64'h0, 32'h100);
    send_sts(8'h00);
    idle(10);
    pin_cmd("t6", 0, 64'h0, 32'h100);
    pin_sts("t6", 0, 8'h00);
    drained("t6", 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_cmd_splitter.md
Name: mem_cmd_splitter

Overview:
- Sits directly upstream of the DMA/memory data mover, on the axis_mem_cmd / axis_mem_status path.
- Accepts arbitrary-length memory commands (64-bit address, 32-bit byte length).
- Issues sub-commands that never cross a BOUNDARY-byte address boundary and never exceed MAX_BYTES.
- Merges the per-chunk status bytes returned by the data mover into one status per original command.

Parameters:
BOUNDARY, 4096, address boundary in bytes no sub-command may cross; power of two
MAX_BYTES, 4096, maximum sub-command length in bytes; power of two, <= BOUNDARY
FLAG_DEPTH, 32, depth of the outstanding-chunk flag FIFO; power of two, >= 2

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_cmd_valid  in  1  upstream command valid
s_cmd_ready  out  1  upstream command ready
s_cmd_address  in  64  start byte address
s_cmd_length  in  32  length in bytes
m_cmd_valid  out  1  sub-command valid
m_cmd_ready  in  1  sub-command ready
m_cmd_address  out  64  sub-command address
m_cmd_length  out  32  sub-command length
s_sts_valid  in  1  per-chunk status valid
s_sts_ready  out  1  per-chunk status ready
s_sts_data  in  8  per-chunk status byte
m_sts_valid  out  1  merged status valid
m_sts_ready  in  1  merged status ready
m_sts_data  out  8  merged status byte

Behaviour:
- Interface: one clock, aclk; reset aresetn is asynchronous, active-low. Assertion immediately clears all state regardless of any transaction in flight.
- Reset values:
  - s_cmd_ready, m_cmd_valid, s_sts_ready, m_sts_valid = 0.
  - m_cmd_address, m_cmd_length, m_sts_data = 0.
  - FSM = IDLE; flag FIFO empty; status accumulator = 0.
- Handshakes: a transfer occurs when valid && ready on a rising edge. Once valid is asserted, payload is held stable until the transfer; valid is never dropped before it.
- Split FSM:
  - IDLE: s_cmd_ready = 1. On accept, latch addr and rem = length; go to SPLIT. m_cmd_valid rises the next cycle.
  - SPLIT: s_cmd_ready = 0. chunk = min(rem, MAX_BYTES, BOUNDARY - (addr mod BOUNDARY)).
    - m_cmd_valid = 1 only while the flag FIFO is not full. m_cmd_address = addr, m_cmd_length = chunk.
    - On transfer: push flag last = (rem == chunk); addr += chunk (64-bit, wraps modulo 2^64); rem -= chunk.
    - If last, go to IDLE, otherwise remain in SPLIT.
- Zero-length command: exactly one sub-command with length 0, flag last = 1.
- Command throughput: at most one sub-command per cycle. Idle gap of exactly one cycle in IDLE between consecutive input commands.
- Flag FIFO:
  - 1-bit entries, FLAG_DEPTH deep. Full/empty are registered.
  - Push and pop in the same cycle are both honoured.
  - When full, m_cmd_valid = 0 and FSM state is held.
- Status merge:
  - s_sts_ready = (flag FIFO not empty) && !m_sts_valid.
  - On status transfer: pop one flag; acc |= s_sts_data.
  - If popped flag = 1: m_sts_data = acc | s_sts_data, m_sts_valid = 1 from the next cycle; acc cleared.
  - m_sts_valid holds until m_sts_ready.
  - Status with empty flag FIFO is never accepted (s_sts_ready = 0).
- Decoupling: split and merge paths are independent. Statuses may return while the command is still being split, so there is no deadlock as long as FIFO space remains.
- Ordering: statuses are assumed to return in sub-command issue order; merged statuses emerge in command order.

Test Plan:
1. Boundary crossing: cmd addr 0x0FF0, len 0x30 -> m_cmd (0x0FF0, 0x10) then (0x1000, 0x20); return statuses 0x00, 0x00 -> one m_sts 0x00.
2. Long command: addr 0x0, len 10000 -> (0x0, 4096), (0x1000, 4096), (0x2000, 1808). Statuses 0x00, 0x80, 0x01 -> single m_sts 0x81, emitted only after the third status.
3. Zero length: addr 0x1234, len 0 -> one m_cmd (0x1234, 0); status 0x40 -> m_sts 0x40.
4. Backpressure and FIFO full: FLAG_DEPTH=4, len 8*4096 at addr 0, m_cmd_ready toggling, no statuses returned.
   - Payload stays stable while stalled.
   - After 4 transfers m_cmd_valid = 0.
   - Returning one status re-enables exactly one further sub-command.
5. Overlap and m_sts stall: two back-to-back commands, 2 chunks each; m_sts_ready = 0 for 5 cycles.
   - s_sts_ready = 0 while m_sts_valid is pending.
   - Merged statuses emerge in command order.
   - s_cmd_ready is low during SPLIT.
6. Reset mid-split: assert aresetn = 0 after the 1st of 3 chunks.
   - All valids drop asynchronously and FIFO is empty.
   - After release, a new cmd (0x0, 0x100) yields a single m_cmd (0x0, 0x100).
